jk_fsm_array: RTL and testbench

- Parametrised successor to the single-channel two-state JK FSM (OFF/ON, set by j, cleared by k).
- Instantiates N independent JK state machines sharing one clock and reset.
- Adds two things the single-channel FSM lacks: a selectable j=k=1 conflict policy and a per-channel minimum-dwell lockout.
- Emits registered edge pulses per channel and a saturating, clearable aggregate transition counter.
- Used by control logic that tracks several on/off requests with glitch-resistant state.

---
 rtl/jk_fsm_array.sv | 112 +++++++++++
 tb/tb_jk_fsm_array.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/jk_fsm_array.sv
// N independent two-state JK machines with a selectable j=k=1 conflict policy,
// per-channel dwell lockout, registered edge pulses and a saturating transition count.
module jk_fsm_array #(
  parameter int N         = 4,
  parameter int MIN_DWELL = 2,
  parameter int CNT_W     = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [N-1:0]     j,
  input  logic [N-1:0]     k,
  input  logic             cnt_clr,
  output logic [N-1:0]     out,
  output logic [N-1:0]     rise,
  output logic [N-1:0]     fall,
  output logic [N-1:0]     locked,
  output logic [CNT_W-1:0] trans_cnt
);
  // Six guard bits hold a full 32-lane popcount on top of the count.
  localparam int SW = CNT_W + 6;

  logic [N-1:0]  trans;
  logic [SW-1:0] inc, sum;

  for (genvar i = 0; i < N; i++) begin : gen_lane
    jk_lane #(.MIN_DWELL(MIN_DWELL)) u_lane (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .en       (en),
      .mode     (mode),
      .j        (j[i]),
      .k        (k[i]),
      .out      (out[i]),
      .rise     (rise[i]),
      .fall     (fall[i]),
      .locked   (locked[i]),
      .trans    (trans[i])
    );
  end

  // Count transitions on the edge that makes them, so the count tracks the pulses.
  always_comb begin
    inc = '0;
    for (int i = 0; i < N; i++) inc = inc + SW'(trans[i]);
    sum = {6'b0, trans_cnt} + inc;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                       trans_cnt <= '0;
    else if (cnt_clr)                     trans_cnt <= '0;
    else if (sum > {6'b0, {CNT_W{1'b1}}}) trans_cnt <= '1;
    else                                  trans_cnt <= sum[CNT_W-1:0];
  end
endmodule

module jk_lane #(
  parameter int MIN_DWELL = 2
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic en,
  input  logic mode,
  input  logic j,
  input  logic k,
  output logic out,
  output logic rise,
  output logic fall,
  output logic locked,
  output logic trans
);
  localparam int DW = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;

  typedef enum logic {OFF = 1'b0, ON = 1'b1} state_t;
  state_t        state, state_nxt;
  logic [DW-1:0] dwell;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= OFF;
    else            state <= state_nxt;
  end

  // mode=1 turns j=k=1 into a hold instead of a toggle.
  always_comb begin
    state_nxt = state;
    if (en && !locked) begin
      case (state)
        OFF:     if (j && (!k || !mode)) state_nxt = ON;
        ON:      if (k && (!j || !mode)) state_nxt = OFF;
        default: state_nxt = OFF;
      endcase
    end
  end

  assign trans  = (state_nxt != state);
  assign out    = (state == ON);
  assign locked = (dwell != '0);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rise  <= 1'b0;
      fall  <= 1'b0;
      dwell <= '0;
    end else begin
      rise <= trans && (state_nxt == ON);
      fall <= trans && (state_nxt == OFF);
      if (trans)                 dwell <= DW'(MIN_DWELL);
      else if (en && locked)     dwell <= dwell - DW'(1);
    end
  end
endmodule

// File: tb/tb_jk_fsm_array.sv
// Drives a D=0/CNT_W=8 and a D=2/CNT_W=3 instance with shared stimulus and
// checks both against an edge-count reference model plus fixed expectations.
module tb_jk_fsm_array;
  localparam int N = 4;

  logic         sys_clk = 1'b0, sys_rst_n = 1'b0;
  logic         en = 1'b0, mode = 1'b0, cnt_clr = 1'b0;
  logic [N-1:0] j = '0, k = '0;
  logic [N-1:0] out0, rise0, fall0, locked0, out2, rise2, fall2, locked2;
  logic [7:0]   cnt0;
  logic [2:0]   cnt2;

  always #5 sys_clk = ~sys_clk;

  jk_fsm_array #(.N(N), .MIN_DWELL(0), .CNT_W(8)) dut0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .mode(mode), .j(j), .k(k),
    .cnt_clr(cnt_clr), .out(out0), .rise(rise0), .fall(fall0), .locked(locked0),
    .trans_cnt(cnt0));

  jk_fsm_array #(.N(N), .MIN_DWELL(2), .CNT_W(3)) dut2 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .mode(mode), .j(j), .k(k),
    .cnt_clr(cnt_clr), .out(out2), .rise(rise2), .fall(fall2), .locked(locked2),
    .trans_cnt(cnt2));

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a channel may change only once more than D enabled edges
  // have passed since its last change.
  int m_dw[2]   = '{0, 2};
  int m_max[2]  = '{255, 7};
  int m_st[2][N], m_since[2][N], m_cnt[2];
  bit m_rise[2][N], m_fall[2][N];

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0;
      for (int i = 0; i < N; i++) begin
        m_st[d][i] = 0; m_since[d][i] = 1000; m_rise[d][i] = 0; m_fall[d][i] = 0;
      end
    end
  endfunction

  function automatic void model_step();
    for (int d = 0; d < 2; d++) begin
      int ntr = 0;
      for (int i = 0; i < N; i++) begin
        int want = m_st[d][i];
        m_rise[d][i] = 0; m_fall[d][i] = 0;
        if (en && m_since[d][i] >= m_dw[d]) begin
          if (j[i] && !k[i])      want = 1;
          else if (k[i] && !j[i]) want = 0;
          else if (j[i] && k[i])  want = mode ? m_st[d][i] : 1 - m_st[d][i];
        end
        if (want != m_st[d][i]) begin
          m_rise[d][i] = (want == 1); m_fall[d][i] = (want == 0);
          m_st[d][i] = want; m_since[d][i] = 0; ntr++;
        end else if (en && m_since[d][i] < 1000) m_since[d][i]++;
      end
      if (cnt_clr) m_cnt[d] = 0;
      else         m_cnt[d] = (m_cnt[d] + ntr > m_max[d]) ? m_max[d] : m_cnt[d] + ntr;
    end
  endfunction

  function automatic logic [N-1:0] pk(input int d, input int sel);
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++)
      case (sel)
        0: v[i] = (m_st[d][i] != 0);
        1: v[i] = m_rise[d][i];
        2: v[i] = m_fall[d][i];
        default: v[i] = (m_since[d][i] < m_dw[d]);
      endcase
    return v;
  endfunction

  task automatic compare_all();
    chk("d0_out",    32'(out0),    32'(pk(0, 0)));
    chk("d0_rise",   32'(rise0),   32'(pk(0, 1)));
    chk("d0_fall",   32'(fall0),   32'(pk(0, 2)));
    chk("d0_locked", 32'(locked0), 32'(pk(0, 3)));
    chk("d0_cnt",    32'(cnt0),    32'(m_cnt[0]));
    chk("d2_out",    32'(out2),    32'(pk(1, 0)));
    chk("d2_rise",   32'(rise2),   32'(pk(1, 1)));
    chk("d2_fall",   32'(fall2),   32'(pk(1, 2)));
    chk("d2_locked", 32'(locked2), 32'(pk(1, 3)));
    chk("d2_cnt",    32'(cnt2),    32'(m_cnt[1]));
  endtask

  task automatic step(input bit e, input bit m, input logic [N-1:0] jj, input logic [N-1:0] kk,
                      input bit c);
    en = e; mode = m; j = jj; k = kk; cnt_clr = c;
    @(posedge sys_clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    en = 1'b0; j = '0; k = '0; cnt_clr = 1'b0;
    model_reset();
    #2;
    compare_all();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  typedef struct {
    bit           e, m;
    logic [N-1:0] j, k;
    bit           c;
    logic [N-1:0] o, r, f;
    logic [7:0]   cnt;
  } vec_t;
  vec_t tbl[9];

  initial begin
    // Expected values for the D=0 instance
    tbl[0] = '{1, 0, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 4'b0000, 8'd1};
    tbl[1] = '{1, 0, 4'b0000, 4'b0000, 0, 4'b0001, 4'b0000, 4'b0000, 8'd1};
    tbl[2] = '{1, 0, 4'b0001, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0001, 8'd2};
    tbl[3] = '{1, 0, 4'b0000, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0000, 8'd2};
    tbl[4] = '{1, 1, 4'b0010, 4'b0010, 0, 4'b0000, 4'b0000, 4'b0000, 8'd2};
    tbl[5] = '{1, 1, 4'b0010, 4'b0010, 0, 4'b0000, 4'b0000, 4'b0000, 8'd2};
    tbl[6] = '{1, 1, 4'b0010, 4'b0010, 0, 4'b0000, 4'b0000, 4'b0000, 8'd2};
    tbl[7] = '{1, 1, 4'b0010, 4'b0000, 0, 4'b0010, 4'b0010, 4'b0000, 8'd3};
    tbl[8] = '{1, 1, 4'b0010, 4'b0010, 0, 4'b0010, 4'b0000, 4'b0000, 8'd3};

    do_reset();
    for (int t = 0; t < 9; t++) begin
      step(tbl[t].e, tbl[t].m, tbl[t].j, tbl[t].k, tbl[t].c);
      chk($sformatf("tbl%0d_out", t),  32'(out0),  32'(tbl[t].o));
      chk($sformatf("tbl%0d_rise", t), 32'(rise0), 32'(tbl[t].r));
      chk($sformatf("tbl%0d_fall", t), 32'(fall0), 32'(tbl[t].f));
      chk($sformatf("tbl%0d_cnt", t),  32'(cnt0),  32'(tbl[t].cnt));
    end

    // Dwell lockout on the D=2 instance: next change is three edges after the first
    do_reset();
    step(1, 0, 4'b0100, 4'b0000, 0);
    chk("dw_on",       32'(out2[2]),    1);
    chk("dw_lock0",    32'(locked2[2]), 1);
    step(1, 0, 4'b0000, 4'b0100, 0);
    chk("dw_hold1",    32'(out2[2]),    1);
    chk("dw_lock1",    32'(locked2[2]), 1);
    step(1, 0, 4'b0000, 4'b0100, 0);
    chk("dw_hold2",    32'(out2[2]),    1);
    chk("dw_unlock",   32'(locked2[2]), 0);
    step(1, 0, 4'b0000, 4'b0100, 0);
    chk("dw_off",      32'(out2[2]),    0);
    chk("dw_fall",     32'(fall2[2]),   1);
    chk("dw_cnt",      32'(cnt2),       2);

    // Saturation at 7 then clear winning over a same-edge increment
    do_reset();
    for (int t = 0; t < 7; t++) step(1, 0, 4'b1111, 4'b1111, 0);
    chk("sat_cnt", 32'(cnt2), 7);
    step(1, 0, 4'b0000, 4'b0000, 0);
    step(1, 0, 4'b0000, 4'b0000, 0);
    step(1, 0, 4'b1111, 4'b1111, 1);
    chk("clr_cnt2",  32'(cnt2),  0);
    chk("clr_cnt0",  32'(cnt0),  0);
    chk("clr_fall2", 32'(fall2), 4'b1111);

    // Global enable freeze
    for (int t = 0; t < 5; t++) step(0, 0, 4'b1111, 4'b0000, 0);
    chk("en0_out0",  32'(out0),    0);
    chk("en0_out2",  32'(out2),    0);
    chk("en0_lock2", 32'(locked2), 4'b1111);
    chk("en0_cnt0",  32'(cnt0),    0);
    chk("en0_rise0", 32'(rise0),   0);
    step(1, 0, 4'b1111, 4'b0000, 0);
    chk("en1_out0",  32'(out0),    4'b1111);
    chk("en1_rise0", 32'(rise0),   4'b1111);
    chk("en1_out2",  32'(out2),    0);

    // Asynchronous reset while ch3 is ON and locked
    do_reset();
    step(1, 0, 4'b1000, 4'b0000, 0);
    chk("ar_on",   32'(out2[3]),    1);
    chk("ar_lock", 32'(locked2[3]), 1);
    #3;
    sys_rst_n = 1'b0;
    model_reset();
    #1;
    chk("ar_out",   32'(out2),    0);
    chk("ar_lock0", 32'(locked2), 0);
    chk("ar_cnt",   32'(cnt2),    0);
    chk("ar_rise",  32'(rise2),   0);
    #2;
    sys_rst_n = 1'b1;
    step(1, 0, 4'b1000, 4'b0000, 0);
    chk("ar_reacc", 32'(out2[3]), 1);

    // Random traffic against the model
    for (int t = 0; t < 400; t++)
      step($urandom_range(0, 7) != 0, $urandom_range(0, 1) != 0,
           N'($urandom), N'($urandom), $urandom_range(0, 15) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
